// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared definitions for the conv datapath sequencers: operand
//             width, default accumulator width and the MAC sequencer states.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package conv_pkg;

    localparam int OPND_W        = 8;
    localparam int ACC_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mac_addr_gen
//  Purpose  : Operand address generator for the MAC sequencer. Latches both
//             base addresses and the vector length when a job is accepted,
//             then steps a shared index once per fetch cycle.
//  Ports    : clk, rst_n      clock, async active-low reset
//             load           capture base_a/base_b/len, clear the index
//             step           advance the index by one
//             base_a/base_b  first address of each operand vector
//             len            number of elements in the job
//             a_addr/b_addr  base + index, wrapping modulo 2^ADDR_W
//             last           index points at element len-1
//  Revision : 1.0  initial release
// ============================================================================
module mac_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              last
);

    logic [ADDR_W-1:0] r_base_a;
    logic [ADDR_W-1:0] r_base_b;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [ADDR_W-1:0] w_idx_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_a <= '0;
            r_base_b <= '0;
            r_len    <= '0;
            r_idx    <= '0;
        end else if (load) begin
            r_base_a <= base_a;
            r_base_b <= base_b;
            r_len    <= len;
            r_idx    <= '0;
        end else if (step) begin
            r_idx    <= r_idx + LEN_W'(1);
        end
    end

    // Resizing the index to the address width makes base+i wrap naturally.
    assign w_idx_addr = ADDR_W'(r_idx);
    assign a_addr     = r_base_a + w_idx_addr;
    assign b_addr     = r_base_b + w_idx_addr;
    assign last       = (r_idx == (r_len - LEN_W'(1)));

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_ctrl
//  Purpose  : Sequencer for the shared 8x8 signed multiplier. Reads len
//             operand pairs from SRAM A/B, feeds them to the external
//             multiplier, accumulates the products and returns the dot
//             product over a valid/ready handshake.
//  Ports    : clk, rst_n               clock, async active-low reset
//             start, abort             job launch / synchronous cancel
//             base_a, base_b, len      job descriptor, latched on accept
//             busy                     job in progress
//             a/b_rd_en, a/b_addr      operand SRAM read ports
//             a/b_rdata                SRAM data, one cycle after rd_en
//             mul_a, mul_b, mul_o      external multiplier interface
//             result, result_valid,
//             result_ready             dot-product output handshake
//  Revision : 1.0  initial release
// ============================================================================
module mac_seq_ctrl
    import conv_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [OPND_W-1:0] a_rdata,
    input  logic [OPND_W-1:0] b_rdata,
    output logic [OPND_W-1:0] mul_a,
    output logic [OPND_W-1:0] mul_b,
    input  logic [ACC_W-1:0]  mul_o,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_rd_en;
    logic             w_last;
    logic             r_rd_v;
    logic [ACC_W-1:0] r_acc;

    assign w_accept = (r_state == IDLE) && start;

    mac_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_accept),
        .step   (w_rd_en),
        .base_a (base_a),
        .base_b (base_b),
        .len    (len),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .last   (w_last)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (len != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = abort ? IDLE : DONE;
            end
            DONE: begin
                // abort wins over a same-cycle handshake; both land in IDLE
                if (abort || result_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy         = 1'b0;
        w_rd_en      = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            FETCH: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign a_rd_en = w_rd_en;
    assign b_rd_en = w_rd_en;

    // ------------------------------------------------ read pipeline and MAC
    // A read issued in the aborting cycle is dropped so the returning data
    // never reaches the multiplier once the sequencer is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v <= 1'b0;
        end else begin
            r_rd_v <= w_rd_en && !abort;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_rd_v) begin
            r_acc <= r_acc + mul_o;
        end
    end

    // Operands are forced to zero between reads so the multiplier input
    // only toggles on real data.
    assign mul_a  = r_rd_v ? a_rdata : '0;
    assign mul_b  = r_rd_v ? b_rdata : '0;
    assign result = r_acc;

endmodule
`default_nettype wire
